// File: rtl/instruction_fetch.sv
// Fetch unit: assembles 24-bit instructions from an 8-bit memory port and keeps
// one current word plus one prefetched word at current + 3.
module instruction_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] program_counter,
  output logic [23:0] instruction_bus,
  output logic        instruction_ready,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, BYTE2} state_t;

  state_t      state, state_nxt;
  logic        cur_valid, pre_valid;
  logic [15:0] cur_addr, pre_addr;
  logic [23:0] cur_word, pre_word;
  logic [15:0] fetch_addr, fetch_addr_nxt, mem_address_nxt;
  logic [7:0]  lane0, lane1;
  logic        hit, eff_cur, eff_pre;
  logic        have_target, target_cur;
  logic [15:0] target;
  logic        done, match, store;
  logic [23:0] word;

  assign instruction_ready = cur_valid && (cur_addr == program_counter);
  assign instruction_bus   = cur_word;
  assign hit     = !instruction_ready && pre_valid && (pre_addr == program_counter);

  // Target is chosen against the buffer contents as they will be after this
  // edge, so a promotion starts the next prefetch on the same edge.
  assign eff_cur = instruction_ready || hit;
  assign eff_pre = instruction_ready && pre_valid;

  always_comb begin
    have_target = 1'b1;
    target_cur  = 1'b1;
    target      = program_counter;
    if (eff_cur) begin
      target_cur  = 1'b0;
      target      = program_counter + 16'd3;
      have_target = !eff_pre;
    end
  end

  assign done  = (state != IDLE) && mem_ready;
  assign match = have_target && (fetch_addr == target);
  assign store = (state == BYTE2) && done && match;
  assign word  = {lane0, lane1, mem_data};

  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    case (state)
      IDLE: begin
        if (have_target) begin
          state_nxt      = BYTE0;
          fetch_addr_nxt = target;
        end
      end
      BYTE0, BYTE1: begin
        if (done) begin
          if (match) begin
            state_nxt = (state == BYTE0) ? BYTE1 : BYTE2;
          end else if (have_target) begin
            state_nxt      = BYTE0;
            fetch_addr_nxt = target;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      BYTE2: begin
        if (done) state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_nxt)
      BYTE1:   mem_address_nxt = fetch_addr_nxt + 16'd1;
      BYTE2:   mem_address_nxt = fetch_addr_nxt + 16'd2;
      default: mem_address_nxt = fetch_addr_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_addr  <= 16'h0000;
      mem_read    <= 1'b0;
      mem_address <= 16'h0000;
      cur_valid   <= 1'b0;
      pre_valid   <= 1'b0;
      cur_addr    <= 16'h0000;
      pre_addr    <= 16'h0000;
      cur_word    <= 24'h000000;
    end else begin
      state       <= state_nxt;
      fetch_addr  <= fetch_addr_nxt;
      mem_read    <= (state_nxt != IDLE);
      mem_address <= mem_address_nxt;
      if (!instruction_ready) begin
        if (hit) begin
          cur_valid <= 1'b1;
          cur_addr  <= pre_addr;
          cur_word  <= pre_word;
        end else begin
          cur_valid <= 1'b0;
        end
        pre_valid <= 1'b0;
      end
      if (store) begin
        if (target_cur) begin
          cur_valid <= 1'b1;
          cur_addr  <= fetch_addr;
          cur_word  <= word;
        end else begin
          pre_valid <= 1'b1;
          pre_addr  <= fetch_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (done && (state == BYTE0)) lane0 <= mem_data;
    if (done && (state == BYTE1)) lane1 <= mem_data;
    if (store && !target_cur)     pre_word <= word;
  end

endmodule
